// File: rtl/somador_serial8.sv
// Bit-serial 8-bit adder: one full-adder cell plus a carry flop, iterated LSB first
// over eight clocks, with a start/busy/done handshake toward the ALU controller.
module somador_serial8 (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic       Cin,
   output logic [7:0] S,
   output logic       Cout,
   output logic       Overflow,
   output logic       busy,
   output logic       done
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0] state;
   logic [7:0] ra;
   logic [7:0] rb;
   logic [7:0] sr;
   logic       c;
   logic [2:0] k;

   logic       s_bit;
   logic       c_next;
   logic       accept;

   // NOTE: every signal written here gets a value on every path, so no latch is inferred.
   always_comb begin
      s_bit  = ra[0] ^ rb[0] ^ c;
      c_next = (ra[0] & rb[0]) | (ra[0] & c) | (rb[0] & c);
   end

   assign accept = start && ((state == IDLE) || (state == DONE));
   assign busy   = (state == RUN);
   assign done   = (state == DONE);

   // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         ra       <= '0;
         rb       <= '0;
         sr       <= '0;
         c        <= 1'b0;
         k        <= '0;
         S        <= '0;
         Cout     <= 1'b0;
         Overflow <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  ra    <= A;
                  rb    <= B;
                  c     <= Cin;
                  sr    <= '0;
                  k     <= '0;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               ra <= {1'b0, ra[7:1]};
               rb <= {1'b0, rb[7:1]};
               sr <= {s_bit, sr[7:1]};
               c  <= c_next;
               k  <= k + 3'd1;
               // On the last bit, c is still the carry into bit 7 for the overflow test.
               if (k == 3'd7) begin
                  S        <= {s_bit, sr[7:1]};
                  Cout     <= c_next;
                  Overflow <= c ^ c_next;
                  state    <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_somador_serial8.sv
// Self-checking bench for somador_serial8: directed handshake cases plus randomized
// operands compared against an integer-arithmetic reference model.
module tb_somador_serial8;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] A;
   logic [7:0] B;
   logic       Cin;
   logic [7:0] S;
   logic       Cout;
   logic       Overflow;
   logic       busy;
   logic       done;

   int errors = 0;
   int checks = 0;

   logic [7:0] last_s    = 8'h00;
   logic       last_cout = 1'b0;
   logic       last_ovf  = 1'b0;
   logic       mon_en    = 1'b0;
   logic       prev_done = 1'b0;

   somador_serial8 dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .A        (A),
      .B        (B),
      .Cin      (Cin),
      .S        (S),
      .Cout     (Cout),
      .Overflow (Overflow),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: unsigned sum for S/Cout, signed sum range test for Overflow.
   function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic ci);
      int u;
      int sg;
      logic ov;
      u  = int'(a) + int'(b) + int'(ci);
      sg = int'($signed(a)) + int'($signed(b)) + int'(ci);
      ov = (sg > 127) || (sg < -128);
      return {ov, (u > 255), 8'(u)};
   endfunction

   // busy/done exclusivity and single-cycle done, every cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         check("busy_done_excl", 32'(busy && done), 32'd0);
         check("done_single", 32'(done && prev_done), 32'd0);
      end
      prev_done = done;
   end

   // Drives one operation and checks busy window, held outputs and the done cycle.
   // b2b: start is raised in the current (DONE) cycle instead of waiting a cycle.
   // repulse: start is re-pulsed with other operands during the run.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                         input logic repulse, input logic b2b, input string tag);
      logic [9:0] exp;
      exp = model(a, b, ci);
      if (!b2b) @(negedge clk);
      A = a; B = b; Cin = ci; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      A = 8'($urandom); B = 8'($urandom); Cin = 1'($urandom);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         check({tag, "_busy"}, 32'(busy), 32'd1);
         check({tag, "_nodone"}, 32'(done), 32'd0);
         check({tag, "_s_hold"}, 32'(S), 32'(last_s));
         check({tag, "_cout_hold"}, 32'(Cout), 32'(last_cout));
         if (repulse && i == 3) begin
            start = 1'b1; A = 8'h11; B = 8'h22;
         end
         if (repulse && i == 4) start = 1'b0;
      end
      @(negedge clk);
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_busy_off"}, 32'(busy), 32'd0);
      check({tag, "_s"}, 32'(S), 32'(exp[7:0]));
      check({tag, "_cout"}, 32'(Cout), 32'(exp[8]));
      check({tag, "_ovf"}, 32'(Overflow), 32'(exp[9]));
      last_s = exp[7:0]; last_cout = exp[8]; last_ovf = exp[9];
   endtask

   logic [7:0] corner [5];

   initial begin
      corner[0] = 8'h00; corner[1] = 8'h01; corner[2] = 8'h7F;
      corner[3] = 8'h80; corner[4] = 8'hFF;
      reset = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      mon_en = 1'b1;

      repeat (5) begin
         @(negedge clk);
         check("rst_s", 32'(S), 32'h00);
         check("rst_cout", 32'(Cout), 32'd0);
         check("rst_ovf", 32'(Overflow), 32'd0);
         check("rst_busy", 32'(busy), 32'd0);
         check("rst_done", 32'(done), 32'd0);
      end

      run_op(8'h25, 8'h17, 1'b0, 1'b0, 1'b0, "basic");
      check("basic_const", 32'(S), 32'h3C);
      run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, "wrap");
      run_op(8'h7F, 8'h00, 1'b1, 1'b0, 1'b0, "posovf");
      check("posovf_const", 32'({Overflow, Cout, S}), 32'h280);
      run_op(8'h80, 8'h80, 1'b0, 1'b0, 1'b0, "negovf");
      check("negovf_const", 32'({Overflow, Cout, S}), 32'h300);
      run_op(8'h0F, 8'h01, 1'b0, 1'b1, 1'b0, "repulse");
      check("repulse_const", 32'(S), 32'h10);

      run_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b0, "b2b_first");
      run_op(8'hC8, 8'h64, 1'b1, 1'b0, 1'b1, "b2b_second");
      check("b2b_const", 32'({Overflow, Cout, S}), 32'h12D);

      // Reset in the middle of a run after a prior 3C result.
      run_op(8'h25, 8'h17, 1'b0, 1'b0, 1'b0, "pre_rst");
      @(negedge clk);
      A = 8'h0F; B = 8'h01; Cin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrst_s", 32'(S), 32'h00);
      check("midrst_cout", 32'(Cout), 32'd0);
      check("midrst_ovf", 32'(Overflow), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      last_s = 8'h00; last_cout = 1'b0; last_ovf = 1'b0;
      repeat (10) begin
         @(negedge clk);
         check("midrst_idle_done", 32'(done), 32'd0);
         check("midrst_idle_busy", 32'(busy), 32'd0);
      end
      run_op(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0, "post_rst");

      // Reset coincident with start must not accept.
      @(negedge clk);
      reset = 1'b1; start = 1'b1; A = 8'h33; B = 8'h44;
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      last_s = 8'h00; last_cout = 1'b0; last_ovf = 1'b0;
      check("rst_start_busy", 32'(busy), 32'd0);
      check("rst_start_s", 32'(S), 32'h00);
      @(negedge clk);
      check("rst_start_busy2", 32'(busy), 32'd0);
      check("rst_start_done", 32'(done), 32'd0);

      foreach (corner[i]) foreach (corner[j]) for (int ci = 0; ci < 2; ci++)
         run_op(corner[i], corner[j], 1'(ci), 1'b0, 1'b0, "corner");

      for (int n = 0; n < 1500; n++)
         run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'($urandom_range(0, 1)), "rand");

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
